// File: rtl/log_event_arbiter_if.sv
// Event-source and logger-side signal bundle for log_event_arbiter.
// The master side drives events and logger readiness; the slave side is the arbiter.
interface log_event_arbiter_if #(
    parameter int unsigned NUM_SRC       = 4,
    parameter int unsigned SRC_DATA_BITW = 24
);
    logic [NUM_SRC-1:0]               Evt_SI;
    logic [NUM_SRC*SRC_DATA_BITW-1:0] EvtData_DI;
    logic                             LogReady_SI;
    logic                             LogTrigger_SO;
    logic [31:0]                      LogData_DO;

    modport master (
        output Evt_SI,
        output EvtData_DI,
        output LogReady_SI,
        input  LogTrigger_SO,
        input  LogData_DO
    );

    modport slave (
        input  Evt_SI,
        input  EvtData_DI,
        input  LogReady_SI,
        output LogTrigger_SO,
        output LogData_DO
    );
endinterface

// File: rtl/log_event_arbiter.sv
// Serialises events from NUM_SRC sources into one log entry per cycle for the BRAM logger.
// Each source has a one-deep pending slot; slots are served round-robin into a small FIFO.
// Events lost to a full slot are counted and flagged on that source's next logged entry.
module log_event_arbiter #(
    parameter int unsigned NUM_SRC       = 4,
    parameter int unsigned SRC_DATA_BITW = 24,
    parameter int unsigned FIFO_DEPTH    = 8
) (
    input  logic                      Clk_CI,
    input  logic                      Rst_RBI,
    log_event_arbiter_if.slave        bus_io,
    input  logic                      Clear_SI,
    output logic [15:0]               DropCnt_DO,
    output logic                      Busy_SO
);
    localparam int unsigned SRC_ID_BITW = $clog2(NUM_SRC);
    localparam int unsigned FIFO_AW     = $clog2(FIFO_DEPTH);

    typedef logic [SRC_DATA_BITW-1:0] payload_t;

    logic [NUM_SRC-1:0]     slot_full_q, slot_full_d;
    payload_t               slot_data_q [NUM_SRC];
    payload_t               slot_data_d [NUM_SRC];
    logic [NUM_SRC-1:0]     lost_q, lost_d;
    logic [SRC_ID_BITW-1:0] ptr_q, ptr_d;
    logic [31:0]            fifo_q [FIFO_DEPTH];
    logic [31:0]            fifo_d [FIFO_DEPTH];
    logic [FIFO_AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]       count_q, count_d;
    logic [15:0]            drop_cnt_q, drop_cnt_d;

    logic                   fifo_empty, fifo_full, pop, grant_en, grant_valid;
    logic [SRC_ID_BITW-1:0] grant_idx, cand;
    logic [NUM_SRC-1:0]     grant_vec, drop_vec;
    logic [31:0]            entry;
    logic [SRC_ID_BITW:0]   n_drop;
    logic [16:0]            drop_sum;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == (FIFO_AW+1)'(FIFO_DEPTH));
    // Clear suppresses the trigger, so nothing is popped during a flush.
    assign pop        = !fifo_empty && bus_io.LogReady_SI && !Clear_SI;
    assign grant_en   = !fifo_full || pop;

    // Round-robin search from ptr+1 and formatting of the granted entry.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        grant_vec   = '0;
        entry       = '0;
        for (int unsigned k = 1; k <= NUM_SRC; k++) begin
            cand = SRC_ID_BITW'((32'(ptr_q) + k) % NUM_SRC);
            if (grant_en && !grant_valid && slot_full_q[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
        if (grant_valid) begin
            grant_vec[grant_idx]                   = 1'b1;
            entry[31]                              = lost_q[grant_idx];
            entry[SRC_DATA_BITW +: SRC_ID_BITW]    = grant_idx;
            entry[SRC_DATA_BITW-1:0]               = slot_data_q[grant_idx];
        end
    end

    // Next state for slots, lost flags, drop counter, pointer and FIFO; Clear wins over all.
    always_comb begin
        slot_full_d = slot_full_q;
        slot_data_d = slot_data_q;
        lost_d      = lost_q;
        drop_vec    = '0;
        n_drop      = '0;
        fifo_d      = fifo_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        ptr_d       = grant_valid ? grant_idx : ptr_q;

        for (int i = 0; i < int'(NUM_SRC); i++) begin
            drop_vec[i] = bus_io.Evt_SI[i] && slot_full_q[i] && !grant_vec[i];
            if (grant_vec[i]) begin
                slot_full_d[i] = 1'b0;
                lost_d[i]      = 1'b0;
            end
            if (bus_io.Evt_SI[i] && !drop_vec[i]) begin
                slot_full_d[i] = 1'b1;
                slot_data_d[i] = bus_io.EvtData_DI[i*SRC_DATA_BITW +: SRC_DATA_BITW];
            end
            // A drop in the same cycle as a grant keeps the flag for the next entry.
            if (drop_vec[i]) begin
                lost_d[i] = 1'b1;
            end
            n_drop = n_drop + (SRC_ID_BITW+1)'(drop_vec[i]);
        end

        drop_sum   = {1'b0, drop_cnt_q} + 17'(n_drop);
        drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

        if (grant_valid) begin
            fifo_d[wr_ptr_q] = entry;
            wr_ptr_d         = wr_ptr_q + FIFO_AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
        end
        unique case ({grant_valid, pop})
            2'b10:   count_d = count_q + (FIFO_AW+1)'(1);
            2'b01:   count_d = count_q - (FIFO_AW+1)'(1);
            default: count_d = count_q;
        endcase

        if (Clear_SI) begin
            slot_full_d = '0;
            lost_d      = '0;
            drop_cnt_d  = '0;
            ptr_d       = SRC_ID_BITW'(NUM_SRC - 1);
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
        end
    end

    // State registers; reset discards all pending work.
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            slot_full_q <= '0;
            lost_q      <= '0;
            ptr_q       <= SRC_ID_BITW'(NUM_SRC - 1);
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            drop_cnt_q  <= '0;
            for (int i = 0; i < int'(NUM_SRC); i++) begin
                slot_data_q[i] <= '0;
            end
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            slot_full_q <= slot_full_d;
            slot_data_q <= slot_data_d;
            lost_q      <= lost_d;
            ptr_q       <= ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            drop_cnt_q  <= drop_cnt_d;
            fifo_q      <= fifo_d;
        end
    end

    // Outputs derive from registered state plus the logger handshake.
    always_comb begin
        bus_io.LogTrigger_SO = pop;
        bus_io.LogData_DO    = fifo_empty ? 32'h0 : fifo_q[rd_ptr_q];
        DropCnt_DO           = drop_cnt_q;
        Busy_SO              = (|slot_full_q) || !fifo_empty;
    end
endmodule

// File: tb/tb_log_event_arbiter.sv
// Directed bench for log_event_arbiter with hand-computed expected entries.
module tb_log_event_arbiter;
    localparam int unsigned NUM_SRC       = 4;
    localparam int unsigned SRC_DATA_BITW = 24;
    localparam int unsigned FIFO_DEPTH    = 8;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic [15:0] drop_cnt;
    logic        busy;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    log_event_arbiter_if #(.NUM_SRC(NUM_SRC), .SRC_DATA_BITW(SRC_DATA_BITW)) bus ();

    log_event_arbiter #(
        .NUM_SRC       (NUM_SRC),
        .SRC_DATA_BITW (SRC_DATA_BITW),
        .FIFO_DEPTH    (FIFO_DEPTH)
    ) dut (
        .Clk_CI     (clk),
        .Rst_RBI    (rst_n),
        .bus_io     (bus),
        .Clear_SI   (clear),
        .DropCnt_DO (drop_cnt),
        .Busy_SO    (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Inputs change just after the rising edge; outputs are sampled on the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic set_payload(input int src, input logic [23:0] v);
        bus.EvtData_DI[src*SRC_DATA_BITW +: SRC_DATA_BITW] = v;
    endtask

    // All four sources pulse once; expect triggers from sources 0..3 in cycles 2..5.
    task automatic run_burst(input string tag, input logic [23:0] base);
        bus.Evt_SI = 4'b1111;
        for (int i = 0; i < 4; i++) set_payload(i, base + 24'(i));
        sample();
        next_cycle();
        bus.Evt_SI = 4'b0000;
        sample();
        check_eq({tag, "_gap"}, 32'(bus.LogTrigger_SO), 32'd0);
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            sample();
            check_eq({tag, "_trig"}, 32'(bus.LogTrigger_SO), 32'd1);
            check_eq({tag, "_data"}, bus.LogData_DO, (32'(k) << 24) | 32'(base + 24'(k)));
        end
        next_cycle();
        sample();
        check_eq({tag, "_idle"}, 32'(bus.LogTrigger_SO), 32'd0);
    endtask

    initial begin
        bus.Evt_SI      = '0;
        bus.EvtData_DI  = '0;
        bus.LogReady_SI = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        sample();
        check_eq("rst_trig", 32'(bus.LogTrigger_SO), 32'd0);
        check_eq("rst_data", bus.LogData_DO, 32'd0);
        check_eq("rst_drop", 32'(drop_cnt), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);

        // Single event: trigger exactly two cycles later
        next_cycle();
        bus.Evt_SI      = 4'b0001;
        bus.LogReady_SI = 1'b1;
        set_payload(0, 24'hABCDEF);
        sample();
        check_eq("single_c0", 32'(bus.LogTrigger_SO), 32'd0);
        next_cycle();
        bus.Evt_SI = 4'b0000;
        sample();
        check_eq("single_c1", 32'(bus.LogTrigger_SO), 32'd0);
        next_cycle();
        sample();
        check_eq("single_c2_trig", 32'(bus.LogTrigger_SO), 32'd1);
        check_eq("single_c2_data", bus.LogData_DO, 32'h00ABCDEF);
        check_eq("single_c2_drop", 32'(drop_cnt), 32'd0);
        next_cycle();
        sample();
        check_eq("single_c3_trig", 32'(bus.LogTrigger_SO), 32'd0);
        check_eq("single_c3_busy", 32'(busy), 32'd0);

        // Fairness: pointer back to NUM_SRC-1 via clear, then two bursts
        next_cycle();
        clear = 1'b1;
        sample();
        next_cycle();
        clear = 1'b0;
        run_burst("fair1", 24'd1);
        next_cycle();
        run_burst("fair2", 24'd5);

        // Overflow: logger stalled, source 2 pulses 20 cycles
        next_cycle();
        bus.LogReady_SI = 1'b0;
        for (int c = 0; c < 20; c++) begin
            bus.Evt_SI = 4'b0100;
            set_payload(2, 24'h100 + 24'(c));
            next_cycle();
        end
        bus.Evt_SI = 4'b0000;
        sample();
        check_eq("ovf_drop", 32'(drop_cnt), 32'd11);
        check_eq("ovf_busy", 32'(busy), 32'd1);
        check_eq("ovf_trig", 32'(bus.LogTrigger_SO), 32'd0);
        next_cycle();
        bus.LogReady_SI = 1'b1;
        for (int k = 0; k < 9; k++) begin
            sample();
            check_eq("ovf_drain_trig", 32'(bus.LogTrigger_SO), 32'd1);
            check_eq("ovf_drain_data", bus.LogData_DO,
                     (k == 8) ? 32'h8200_0108 : (32'h0200_0100 + 32'(k)));
            next_cycle();
        end
        sample();
        check_eq("ovf_done_trig", 32'(bus.LogTrigger_SO), 32'd0);
        check_eq("ovf_done_busy", 32'(busy), 32'd0);
        check_eq("ovf_done_drop", 32'(drop_cnt), 32'd11);

        // Back-to-back events on source 1
        next_cycle();
        for (int k = 0; k < 12; k++) begin
            if (k < 10) begin
                bus.Evt_SI = 4'b0010;
                set_payload(1, 24'h200 + 24'(k));
            end else begin
                bus.Evt_SI = 4'b0000;
            end
            sample();
            if (k >= 2) begin
                check_eq("b2b_trig", 32'(bus.LogTrigger_SO), 32'd1);
                check_eq("b2b_data", bus.LogData_DO, 32'h0100_0200 + 32'(k - 2));
            end else begin
                check_eq("b2b_lead", 32'(bus.LogTrigger_SO), 32'd0);
            end
            next_cycle();
        end
        sample();
        check_eq("b2b_idle", 32'(bus.LogTrigger_SO), 32'd0);
        check_eq("b2b_drop", 32'(drop_cnt), 32'd11);

        // Clear mid-burst: 5 queued entries and 3 drops
        next_cycle();
        clear = 1'b1;
        sample();
        next_cycle();
        clear           = 1'b0;
        bus.LogReady_SI = 1'b0;
        bus.Evt_SI      = 4'b1111;
        for (int i = 0; i < 4; i++) set_payload(i, 24'h31 + 24'(i));
        next_cycle();
        for (int i = 0; i < 4; i++) set_payload(i, 24'h41 + 24'(i));
        next_cycle();
        bus.Evt_SI = 4'b0000;
        repeat (4) next_cycle();
        sample();
        check_eq("clr_pre_busy", 32'(busy), 32'd1);
        check_eq("clr_pre_drop", 32'(drop_cnt), 32'd3);
        check_eq("clr_pre_head", bus.LogData_DO, 32'h0000_0031);
        clear           = 1'b1;
        bus.Evt_SI      = 4'b1111;
        bus.LogReady_SI = 1'b1;
        #1;
        check_eq("clr_trig", 32'(bus.LogTrigger_SO), 32'd0);
        next_cycle();
        clear      = 1'b0;
        bus.Evt_SI = 4'b0000;
        sample();
        check_eq("clr_post_busy", 32'(busy), 32'd0);
        check_eq("clr_post_drop", 32'(drop_cnt), 32'd0);
        check_eq("clr_post_trig", 32'(bus.LogTrigger_SO), 32'd0);
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            sample();
            check_eq("clr_quiet", 32'(bus.LogTrigger_SO), 32'd0);
        end

        // Asynchronous reset with entries queued
        next_cycle();
        bus.LogReady_SI = 1'b0;
        bus.Evt_SI      = 4'b1111;
        for (int i = 0; i < 4; i++) set_payload(i, 24'h51 + 24'(i));
        next_cycle();
        bus.Evt_SI = 4'b0000;
        repeat (4) next_cycle();
        bus.LogReady_SI = 1'b1;
        sample();
        check_eq("arst_pre_trig", 32'(bus.LogTrigger_SO), 32'd1);
        check_eq("arst_pre_data", bus.LogData_DO, 32'h0000_0051);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("arst_trig", 32'(bus.LogTrigger_SO), 32'd0);
        check_eq("arst_data", bus.LogData_DO, 32'd0);
        check_eq("arst_busy", 32'(busy), 32'd0);
        check_eq("arst_drop", 32'(drop_cnt), 32'd0);
        next_cycle();
        rst_n = 1'b1;
        run_burst("arst_post", 24'h61);
        sample();
        check_eq("arst_post_busy", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/log_event_arbiter.md
Name: log_event_arbiter

Overview:
- Sits directly upstream of the BRAM logger and produces its log trigger and log data inputs.
- Collects timestamp-worthy events from NUM_SRC independent sources and serialises them into at most one log entry per cycle.
- Each source has a one-deep pending slot; slots are served round-robin and then buffered in a small FIFO.
- Events that cannot be captured are counted and flagged on that source's next logged event, so software can detect gaps in the log.

Parameters:
- NUM_SRC, 4, number of event sources; must be 2..16.
- SRC_DATA_BITW, 24, per-source payload width; SRC_DATA_BITW + SRC_ID_BITW <= 31.
- FIFO_DEPTH, 8, output FIFO entries; power of two, >= 2.
- SRC_ID_BITW, $clog2(NUM_SRC), derived; not to be overridden.

Ports:
- Clk_CI  in  1  single clock for all logic.
- Rst_RBI  in  1  asynchronous active-low reset.
- Evt_SI  in  NUM_SRC  per-source event strobe, one event per high cycle.
- EvtData_DI  in  NUM_SRC*SRC_DATA_BITW  payloads; source i occupies [i*SRC_DATA_BITW +: SRC_DATA_BITW].
- Clear_SI  in  1  synchronous flush of all state (same pulse drives the logger's clear input).
- LogReady_SI  in  1  logger ready AND logging enabled.
- LogTrigger_SO  out  1  log entry presented and consumed this cycle.
- LogData_DO  out  32  formatted entry.
- DropCnt_DO  out  16  saturating count of lost events.
- Busy_SO  out  1  any pending slot or FIFO entry occupied.

Behaviour:
- Reset, async on Rst_RBI low:
  - all pending slots, lost flags and FIFO empty;
  - round-robin pointer = NUM_SRC-1, so source 0 wins first;
  - DropCnt_DO = 0; LogTrigger_SO = 0; LogData_DO = 0; Busy_SO = 0.
  - Reset mid-operation discards everything without emitting it.
- Capture: at the rising edge, source i's slot loads EvtData_DI[i] if Evt_SI[i] is high and either the slot is empty or the slot is being granted this cycle.
- Drop: Evt_SI[i] high while slot i is full and not granted.
  - Event discarded; lost[i] set; DropCnt_DO += 1, saturating at 0xFFFF.
  - Multiple drops in one cycle add the number of dropping sources, still saturating.
- Grant: combinational, only when the FIFO is not full, or is full but popping this cycle.
  - Picks the first full slot searching from pointer+1 modulo NUM_SRC.
  - The granted entry is written to the FIFO at the edge; the pointer updates to the granted index.
  - No grant leaves the pointer unchanged.
  - At most one grant per cycle.
- Entry format:
  - bit31 = lost[i] at grant time;
  - [SRC_DATA_BITW +: SRC_ID_BITW] = i;
  - [SRC_DATA_BITW-1:0] = payload;
  - remaining bits 0.
  - lost[i] clears on grant unless a new drop for source i occurs in the same cycle, in which case it stays set.
- Output:
  - LogTrigger_SO = FIFO non-empty AND LogReady_SI AND NOT Clear_SI.
  - LogData_DO = FIFO head; 0 when empty.
  - Pop on LogTrigger_SO.
  - Simultaneous push and pop on a full FIFO is legal; occupancy is unchanged.
- Latency: Evt_SI high in cycle 0 with everything idle → LogTrigger_SO high in cycle 2 if LogReady_SI is high. Sustained throughput is one entry per cycle.
- Clear_SI: has priority over all other actions.
  - At the edge: empties slots and FIFO, clears lost flags, zeroes DropCnt_DO, resets pointer to NUM_SRC-1.
  - Events arriving in the same cycle are discarded and not counted.
  - LogTrigger_SO is forced low during Clear_SI.
- Busy_SO = any slot full OR FIFO non-empty (registered state only).

Test Plan:
- Single event, idle system: Evt_SI=0001, EvtData_DI[0]=0xABCDEF, LogReady_SI=1 → LogTrigger_SO high exactly in cycle 2, LogData_DO=0x00ABCDEF, DropCnt_DO=0.
- Fairness: all four sources pulse in the same cycle, payloads 1..4 → four consecutive triggers from sources 0,1,2,3; LogData_DO[25:24]=0,1,2,3; then a second burst is served starting at source 0.
- Overflow: LogReady_SI=0, source 2 pulses 20 cycles in a row →
  - FIFO fills to 8, slot 2 holds one more, DropCnt_DO=11, Busy_SO=1;
  - after raising LogReady_SI, 9 triggers;
  - only the 9th entry, the payload held in slot 2 when the FIFO filled, has bit31=1, because drops occurred while it was pending and lost[2] is attached at its grant; the first 8 have bit31=0.
- Back-to-back source: source 1 pulses every cycle with LogReady_SI=1 → one trigger per cycle, no drops, payload order preserved.
- Clear mid-burst: FIFO holding 5 entries, DropCnt_DO=3, Clear_SI pulsed with Evt_SI=1111 → LogTrigger_SO low that cycle; next cycle Busy_SO=0, DropCnt_DO=0, no further triggers.
- Async reset mid-operation: Rst_RBI low between clock edges with FIFO holding entries → outputs go to 0 immediately, without waiting for a clock edge; after release, the first event is granted to source 0 and no stale entries appear.
